// File: rtl/prog_run_sequencer.sv
// Launches the integer square-root program on the CPU: loads the operand into data memory,
// starts the CPU, waits for Ack or a timeout, then reads the result back from data memory.
module prog_run_sequencer #(
    parameter logic [7:0] ADDR_HI      = 8'd16,
    parameter logic [7:0] ADDR_LO      = 8'd17,
    parameter logic [7:0] ADDR_RES     = 8'd18,
    parameter int         START_CYCLES = 2,
    parameter int         TIMEOUT      = 65535
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic [15:0] Operand,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  Result,
    output logic        TimedOut,
    output logic        CpuStart,
    input  logic        CpuAck,
    output logic        MemSel,
    output logic [7:0]  MemAddr,
    output logic [7:0]  MemWrData,
    output logic        MemWrEn,
    input  logic [7:0]  MemRdData
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_HI   = 3'd1;
    localparam logic [2:0] WR_LO   = 3'd2;
    localparam logic [2:0] START   = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] RD_ADDR = 3'd5;
    localparam logic [2:0] RD_CAP  = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    localparam int START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int RUN_W   = $clog2(TIMEOUT + 1);

    logic [2:0]         state_reg, state_next;
    logic [15:0]        op_reg, op_next;
    logic [START_W-1:0] start_cnt_reg, start_cnt_next;
    logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;
    logic [7:0]         result_next;
    logic               timed_out_next;
    logic [7:0]         mem_addr_next;
    logic [7:0]         mem_wr_data_next;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        start_cnt_next = start_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        result_next    = Result;
        timed_out_next = TimedOut;
        case (state_reg)
            IDLE: begin
                if (Req) begin
                    op_next        = Operand;
                    timed_out_next = 1'b0;
                    start_cnt_next = '0;
                    run_cnt_next   = '0;
                    if (Operand == 16'd0) begin
                        state_next  = DONE;
                        result_next = 8'd0;
                    end else begin
                        state_next = WR_HI;
                    end
                end
            end
            WR_HI: state_next = WR_LO;
            WR_LO: begin
                state_next     = START;
                start_cnt_next = '0;
            end
            START: begin
                if (start_cnt_reg == START_W'(START_CYCLES - 1)) begin
                    state_next   = RUN;
                    run_cnt_next = '0;
                end else begin
                    start_cnt_next = start_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // First RUN cycle has run_cnt_reg==0; an Ack seen there is left over from the last run.
                if (CpuAck && run_cnt_reg != '0) begin
                    state_next = RD_ADDR;
                end else if (run_cnt_reg == RUN_W'(TIMEOUT - 1)) begin
                    state_next     = DONE;
                    timed_out_next = 1'b1;
                    result_next    = 8'd0;
                    run_cnt_next   = RUN_W'(TIMEOUT);
                end else begin
                    run_cnt_next = run_cnt_reg + 1'b1;
                end
            end
            RD_ADDR: state_next = RD_CAP;
            RD_CAP: begin
                state_next  = DONE;
                result_next = MemRdData;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        mem_addr_next    = 8'd0;
        mem_wr_data_next = 8'd0;
        case (state_next)
            WR_HI: begin
                mem_addr_next    = ADDR_HI;
                mem_wr_data_next = op_next[15:8];
            end
            WR_LO: begin
                mem_addr_next    = ADDR_LO;
                mem_wr_data_next = op_next[7:0];
            end
            RD_ADDR, RD_CAP: mem_addr_next = ADDR_RES;
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            op_reg        <= 16'd0;
            start_cnt_reg <= '0;
            run_cnt_reg   <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Result        <= 8'd0;
            TimedOut      <= 1'b0;
            CpuStart      <= 1'b0;
            MemSel        <= 1'b1;
            MemAddr       <= 8'd0;
            MemWrData     <= 8'd0;
            MemWrEn       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            start_cnt_reg <= start_cnt_next;
            run_cnt_reg   <= run_cnt_next;
            Busy          <= (state_next != IDLE);
            Done          <= (state_next == DONE);
            Result        <= result_next;
            TimedOut      <= timed_out_next;
            CpuStart      <= (state_next == START);
            MemSel        <= !((state_next == START) || (state_next == RUN));
            MemAddr       <= mem_addr_next;
            MemWrData     <= mem_wr_data_next;
            MemWrEn       <= (state_next == WR_HI) || (state_next == WR_LO);
        end
    end

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Scoreboard bench for prog_run_sequencer with a data-memory model and a CPU model that
// computes the square root of whatever operand the sequencer wrote into memory.
module tb_prog_run_sequencer;

    localparam int TB_START   = 2;
    localparam int TB_TIMEOUT = 100;

    logic        Clk;
    logic        Reset;
    logic        Req;
    logic [15:0] Operand;
    logic        Busy;
    logic        Done;
    logic [7:0]  Result;
    logic        TimedOut;
    logic        CpuStart;
    logic        CpuAck;
    logic        MemSel;
    logic [7:0]  MemAddr;
    logic [7:0]  MemWrData;
    logic        MemWrEn;
    logic [7:0]  MemRdData;

    prog_run_sequencer #(.START_CYCLES(TB_START), .TIMEOUT(TB_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Operand(Operand),
        .Busy(Busy), .Done(Done), .Result(Result), .TimedOut(TimedOut),
        .CpuStart(CpuStart), .CpuAck(CpuAck),
        .MemSel(MemSel), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemWrEn(MemWrEn), .MemRdData(MemRdData)
    );

    typedef struct {
        int result;
        int timed_out;
        int op;
        int accept_cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int st_cnt = 0;
    int viol = 0;

    int   ack_delay = 50;
    bit   ack_never = 0;
    int   start_cyc = 0;
    int   ack_cyc = 0;
    logic cpu_wr;
    logic [7:0] cpu_data;
    logic [7:0] dm [256];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (MemSel && MemWrEn) dm[MemAddr] <= MemWrData;
        if (cpu_wr) dm[18] <= cpu_data;
        MemRdData <= dm[MemAddr];
    end

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // CPU model: drops a stale Ack in the second RUN cycle, writes the root, then raises Ack.
    initial begin
        int n;
        CpuAck = 1'b0;
        cpu_wr = 1'b0;
        cpu_data = 8'd0;
        forever begin
            @(negedge Clk);
            if (Reset && CpuStart) begin
                start_cyc = cyc;
                n = 1;
                forever begin
                    @(negedge Clk);
                    n++;
                    if (!Reset || !Busy) begin
                        cpu_wr = 1'b0;
                        break;
                    end
                    if (n == 4) CpuAck = 1'b0;
                    if (!ack_never && n == ack_delay) begin
                        cpu_data = 8'(isqrt({16'd0, dm[16], dm[17]}));
                        cpu_wr = 1'b1;
                    end
                    if (!ack_never && n == ack_delay + 1) begin
                        cpu_wr = 1'b0;
                        CpuAck = 1'b1;
                        ack_cyc = cyc;
                        break;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per Done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                wr_cnt = 0;
                st_cnt = 0;
            end else begin
                if (MemWrEn) wr_cnt++;
                if (CpuStart) st_cnt++;
                if (MemWrEn && !MemSel) viol++;
                if (Done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("run op=0x%04h result=0x%02h timed_out=%0d cycle=%0d",
                                 e.op, Result, TimedOut, cyc);
                        chk("result", int'(Result), e.result);
                        chk("timed_out", int'(TimedOut), e.timed_out);
                        if (e.op == 0) begin
                            chk("zero_done_latency", cyc, e.accept_cyc);
                            chk("zero_wr_cycles", wr_cnt, 0);
                            chk("zero_start_cycles", st_cnt, 0);
                        end else begin
                            chk("wr_cycles", wr_cnt, 2);
                            chk("start_cycles", st_cnt, TB_START);
                            chk("dm_hi", int'(dm[16]), e.op >> 8);
                            chk("dm_lo", int'(dm[17]), e.op & 255);
                            if (e.timed_out != 0)
                                chk("timeout_latency", cyc - start_cyc, TB_START + TB_TIMEOUT);
                            else
                                chk("ack_latency", cyc - ack_cyc, 3);
                        end
                    end
                    done_cnt++;
                    wr_cnt = 0;
                    st_cnt = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int i;
        @(posedge Clk); #1;
        for (i = 0; i < 200 && Busy; i++) begin
            @(posedge Clk); #1;
        end
        if (Busy) chk("idle_wait_expired", 1, 0);
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < 1000 && done_cnt < target; i++) begin
            @(posedge Clk); #1;
        end
        if (done_cnt < target) chk("done_wait_expired", done_cnt, target);
    endtask

    task automatic push_exp(input int op, input bit never);
        exp_t e;
        e.op = op;
        e.accept_cyc = cyc + 1;
        e.timed_out = (never && op != 0) ? 1 : 0;
        e.result = (op == 0 || never) ? 0 : isqrt(op);
        sb.push_back(e);
    endtask

    task automatic run_op(input int op, input int delay, input bit never, input bit pulse_mid);
        int d0;
        wait_idle();
        ack_delay = delay;
        ack_never = never;
        d0 = done_cnt;
        push_exp(op, never);
        Operand = 16'(op);
        Req = 1'b1;
        @(posedge Clk); #1;
        Req = 1'b0;
        if (pulse_mid) begin
            repeat (20) @(posedge Clk);
            #1;
            Operand = 16'($urandom);
            Req = 1'b1;
            @(posedge Clk); #1;
            Req = 1'b0;
        end
        wait_done(d0 + 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(Busy), 0);
        chk({tag, "_done"}, int'(Done), 0);
        chk({tag, "_cpustart"}, int'(CpuStart), 0);
        chk({tag, "_memwren"}, int'(MemWrEn), 0);
        chk({tag, "_memsel"}, int'(MemSel), 1);
        chk({tag, "_memaddr"}, int'(MemAddr), 0);
        chk({tag, "_memwrdata"}, int'(MemWrData), 0);
        chk({tag, "_result"}, int'(Result), 0);
        chk({tag, "_timedout"}, int'(TimedOut), 0);
    endtask

    initial begin
        int d0;
        Reset = 1'b1;
        Req = 1'b0;
        Operand = 16'd0;
        #2 Reset = 1'b0;
        #6 chk_reset_outputs("por");
        @(posedge Clk); #1;
        Reset = 1'b1;

        run_op(16'h9000, 50, 0, 0);
        run_op(16'h0100, 5, 0, 0);      // stale Ack carried over from the previous run
        run_op(16'hFFFF, 30, 0, 0);
        run_op(16'h0001, 12, 0, 0);
        run_op(16'h0000, 10, 0, 0);
        run_op(16'h2710, 10, 1, 0);     // CPU never acknowledges
        run_op(16'h0051, 8, 0, 0);      // next run clears TimedOut
        run_op(16'h3039, 40, 0, 1);     // Req pulsed while busy

        // Req held high through DONE restarts on the first IDLE cycle.
        wait_idle();
        ack_delay = 10;
        ack_never = 0;
        d0 = done_cnt;
        push_exp(16'h1000, 0);
        Operand = 16'h1000;
        Req = 1'b1;
        wait_done(d0 + 1);
        push_exp(16'h1000, 0);
        @(posedge Clk); #1;
        Req = 1'b0;
        wait_done(d0 + 2);

        // Reset in the middle of RUN: no Done for the aborted run.
        wait_idle();
        ack_never = 1;
        Operand = 16'h1234;
        Req = 1'b1;
        @(posedge Clk); #1;
        Req = 1'b0;
        repeat (15) @(posedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1 chk_reset_outputs("midrun");
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        run_op(16'h0400, 20, 0, 0);

        for (int i = 0; i < 8; i++) begin
            int op;
            op = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 65535));
            run_op(op, int'($urandom_range(5, 60)), 0, 0);
        end

        repeat (20) @(posedge Clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("write_while_cpu_owns_dm", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
